// File: rtl/fb_scanout_pkg.sv
// Shared frame-buffer constants: pixel format, SDRAM burst/address widths,
// bank select width, and the scan-out FSM state type.
package fb_scanout_pkg;
  localparam int PIX_W      = 16;  // RGB565
  localparam int BURST_BITS = 10;
  localparam int ADDR_W     = 22;
  localparam int BANK_W     = 2;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_FLUSH,
    ST_DONE
  } scan_state_t;
endpackage

// File: rtl/fb_scanout_if.sv
// SDRAM read-burst port.
//   master (scan-out): read_burst_req, read_addr, read_burst_len, read_bank
//   slave  (SDRAM)   : read_burst_data_vld, read_burst_data, read_burst_finish
interface fb_scanout_if;
  import fb_scanout_pkg::*;

  logic                  read_burst_req;
  logic [ADDR_W-1:0]     read_addr;
  logic [BURST_BITS-1:0] read_burst_len;
  logic [BANK_W-1:0]     read_bank;
  logic                  read_burst_data_vld;
  pix_t                  read_burst_data;
  logic                  read_burst_finish;

  modport master (
    output read_burst_req, read_addr, read_burst_len, read_bank,
    input  read_burst_data_vld, read_burst_data, read_burst_finish
  );

  modport slave (
    input  read_burst_req, read_addr, read_burst_len, read_bank,
    output read_burst_data_vld, read_burst_data, read_burst_finish
  );
endinterface

// File: rtl/fb_scanout_pixel_fifo.sv
// Synchronous pixel FIFO with flush and registered read data.
//   push/push_data : write one word (ignored when full or flushing)
//   pop            : read one word; rd_data <= head, or 0 when empty/flushing
//   flush          : empty the FIFO this cycle
//   count          : current occupancy
module pixel_fifo
  import fb_scanout_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  pix_t                     push_data,
  input  logic                     pop,
  input  logic                     flush,
  output pix_t                     rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  pix_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           empty;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (pop) rd_data <= '0;
    end else begin
      if (pop) rd_data <= empty ? '0 : mem[rd_ptr];
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: reads the displayed bank from SDRAM in fixed bursts
// and feeds the display pixel pipeline through pixel_fifo.
//   clk, rst_n        : clock, async active-low reset
//   frame_start       : restart scan (disp_bank sampled here)
//   rd                : SDRAM read-burst port (master)
//   pix_req / pix_rgb : pixel pop, data valid the cycle after
//   underflow         : sticky, pop seen on empty FIFO; cleared by frame_start
//   frame_done        : pulse when the last burst of a frame finishes
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [BANK_W-1:0]  disp_bank,
  fb_scanout_if.master       rd,
  input  logic               pix_req,
  output pix_t               pix_rgb,
  output logic               underflow,
  output logic               frame_done
);
  localparam int FRAME_PIX = H_RES * V_RES;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  scan_state_t        state;
  logic [ADDR_W:0]    remaining;
  logic [CNT_W-1:0]   fifo_count;
  logic               restart;
  logic               push;
  logic               space_ok;

  // Restart also covers an in-flight burst: it completes (finish) before the
  // scan can start over, since SDRAM bursts cannot be aborted.
  always_comb begin
    restart = 1'b0;
    unique case (state)
      ST_IDLE, ST_WAIT_SPACE, ST_DONE: restart = frame_start;
      ST_REQ:   restart = rd.read_burst_finish && frame_start;
      ST_FLUSH: restart = rd.read_burst_finish;
      default:  restart = 1'b0;
    endcase
  end

  // Words arriving while a restart is pending (FLUSH) are discarded.
  assign push     = rd.read_burst_data_vld && (state == ST_REQ);
  // Only WAIT_SPACE checks credit and no burst is outstanding there.
  assign space_ok = fifo_count <= CNT_W'(FIFO_DEPTH - BURST_LEN);
  assign rd.read_burst_len = BURST_BITS'(BURST_LEN);

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rd.read_burst_data),
    .pop       (pix_req),
    .flush     (restart),
    .rd_data   (pix_rgb),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      rd.read_burst_req <= 1'b0;
      rd.read_addr      <= '0;
      rd.read_bank      <= '0;
      remaining         <= '0;
      frame_done        <= 1'b0;
      underflow         <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (frame_start)                      underflow <= 1'b0;
      else if (pix_req && fifo_count == '0) underflow <= 1'b1;

      if (restart) begin
        rd.read_bank      <= disp_bank;
        rd.read_addr      <= '0;
        remaining         <= (ADDR_W+1)'(FRAME_PIX);
        rd.read_burst_req <= 1'b0;
        state             <= ST_WAIT_SPACE;
      end else begin
        unique case (state)
          ST_WAIT_SPACE: begin
            if (space_ok) begin
              rd.read_burst_req <= 1'b1;
              state             <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (rd.read_burst_finish) begin
              rd.read_burst_req <= 1'b0;
              rd.read_addr      <= rd.read_addr + ADDR_W'(BURST_LEN);
              remaining         <= remaining - (ADDR_W+1)'(BURST_LEN);
              if (remaining == (ADDR_W+1)'(BURST_LEN)) begin
                frame_done <= 1'b1;
                state      <= ST_DONE;
              end else begin
                state <= ST_WAIT_SPACE;
              end
            end else if (frame_start) begin
              rd.read_bank <= disp_bank;
              state        <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            if (frame_start) rd.read_bank <= disp_bank;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;
  import fb_scanout_pkg::*;

  localparam int H = 8, V = 2, BL = 4, D = 8, FRAME = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  disp_bank = 2'd0;
  logic        pix_req = 1'b0;
  logic [15:0] pix_rgb;
  logic        underflow;
  logic        frame_done;

  fb_scanout_if bus();

  fb_scanout #(.H_RES(H), .V_RES(V), .BURST_LEN(BL), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .disp_bank   (disp_bank),
    .rd          (bus.master),
    .pix_req     (pix_req),
    .pix_rgb     (pix_rgb),
    .underflow   (underflow),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for room, 2 burst in flight, 3 burst in flight
  // but frame restarted (words ignored), 4 frame fully fetched
  int          m_phase, m_addr, m_rem, m_bank;
  bit          m_done, m_uf;
  logic [15:0] m_pix;
  logic [15:0] m_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit fs, rs, do_push, was_empty, was_full;
    if (!rst_n) begin
      m_phase = 0; m_addr = 0; m_rem = 0; m_bank = 0;
      m_done = 0; m_uf = 0; m_pix = 0; m_q.delete();
    end else begin
      fs = frame_start; rs = 0; do_push = 0;
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == D);
      m_done = 0;
      if (m_phase == 0 || m_phase == 1 || m_phase == 4) begin
        if (fs) rs = 1;
        else if (m_phase == 1 && (D - m_q.size()) >= BL) m_phase = 2;
      end else if (m_phase == 2) begin
        do_push = bus.read_burst_data_vld;
        if (bus.read_burst_finish) begin
          m_addr += BL; m_rem -= BL;
          if (fs) rs = 1;
          else if (m_rem == 0) begin m_phase = 4; m_done = 1; end
          else m_phase = 1;
        end else if (fs) begin
          m_bank = disp_bank; m_phase = 3;
        end
      end else begin
        if (fs) m_bank = disp_bank;
        if (bus.read_burst_finish) rs = 1;
      end
      if (fs) m_uf = 0;
      else if (pix_req && was_empty) m_uf = 1;
      if (rs) begin
        m_bank = disp_bank; m_addr = 0; m_rem = FRAME; m_phase = 1;
        if (pix_req) m_pix = 0;
        m_q.delete();
      end else begin
        if (pix_req) m_pix = was_empty ? 16'h0 : m_q.pop_front();
        if (do_push && !was_full) m_q.push_back(bus.read_burst_data);
      end
    end
  end

  // ---------------- stimulus / SDRAM responder state ----------------
  bit          fs_pending = 0, fs_on_final = 0, prev_preq = 0;
  bit          busy = 0, abort_fired = 0;
  int          abort_after = -1;
  logic [1:0]  abort_bank = 0;
  int          left = 0, cur_addr = 0, consume_pct = 0, force_pop = 0, n_done = 0;
  logic [15:0] word = 16'h1;
  int          burst_addrs[$];
  int          burst_banks[$];
  logic [15:0] seen[$];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rst_n) begin
      chk("req",   32'(bus.read_burst_req), 32'(m_phase == 2 || m_phase == 3));
      chk("addr",  32'(bus.read_addr), 32'(m_addr));
      chk("bank",  32'(bus.read_bank), 32'(m_bank));
      chk("done",  32'(frame_done), 32'(m_done));
      chk("pix",   32'(pix_rgb), 32'(m_pix));
      chk("uflow", 32'(underflow), 32'(m_uf));
      chk("len",   32'(bus.read_burst_len), 32'(BL));
      if (frame_done) n_done++;
      if (prev_preq && pix_rgb != 16'h0) seen.push_back(pix_rgb);
    end
    frame_start = 0; pix_req = 0;
    bus.read_burst_data_vld = 0; bus.read_burst_finish = 0;
    if (!rst_n) busy = 0;
    else if (busy) begin
      if (abort_after >= 0 && !abort_fired && left == BL - abort_after) begin
        frame_start = 1; disp_bank = abort_bank; abort_fired = 1;
      end else if (left == 0) begin
        bus.read_burst_finish = 1; busy = 0;
        if (fs_on_final && cur_addr == FRAME - BL) frame_start = 1;
      end else if ($urandom_range(0, 3) != 0) begin
        bus.read_burst_data_vld = 1; bus.read_burst_data = word;
        word++; left--;
      end
    end else if (bus.read_burst_req) begin
      busy = 1; left = BL; cur_addr = int'(bus.read_addr);
      burst_addrs.push_back(int'(bus.read_addr));
      burst_banks.push_back(int'(bus.read_bank));
    end
    if (fs_pending) begin frame_start = 1; fs_pending = 0; end
    if (rst_n && $urandom_range(0, 99) < consume_pct) pix_req = 1;
    if (rst_n && force_pop > 0) begin pix_req = 1; force_pop--; end
    prev_preq = pix_req;
  endtask

  task automatic wait_bursts(int n, int budget, string name);
    for (int i = 0; i < budget && burst_addrs.size() < n; i++) cycle();
    chk(name, 32'(burst_addrs.size() >= n), 32'd1);
  endtask

  task automatic wait_done(int budget, string name);
    for (int i = 0; i < budget && n_done < 1; i++) cycle();
    chk(name, 32'(n_done >= 1), 32'd1);
  endtask

  initial begin : main
    int lit_addr[4];
    logic [15:0] first_w;
    int nb;
    lit_addr = '{0, 4, 8, 12};
    bus.read_burst_data_vld = 0; bus.read_burst_finish = 0; bus.read_burst_data = 0;

    // reset values
    repeat (3) cycle();
    rst_n = 1;
    cycle();
    chk("rst_req", 32'(bus.read_burst_req), 0);
    chk("rst_addr", 32'(bus.read_addr), 0);
    chk("rst_bank", 32'(bus.read_bank), 0);
    chk("rst_pix", 32'(pix_rgb), 0);
    chk("rst_uf", 32'(underflow), 0);
    chk("rst_len", 32'(bus.read_burst_len), 4);

    // pop on empty FIFO: zero pixel, sticky underflow
    force_pop = 1;
    cycle(); cycle();
    chk("t4_pix", 32'(pix_rgb), 0);
    chk("t4_uf", 32'(underflow), 1);
    repeat (5) cycle();
    chk("t4_sticky", 32'(underflow), 1);

    // full frame from bank 2, pixels 1..16 in order
    burst_addrs.delete(); burst_banks.delete(); seen.delete();
    n_done = 0; word = 16'h1; disp_bank = 2; fs_pending = 1;
    cycle(); cycle();
    chk("t4_uf_clr", 32'(underflow), 0);
    consume_pct = 40;
    wait_done(600, "t1_done_timeout");
    for (int i = 0; i < 400 && seen.size() < 16; i++) cycle();
    repeat (10) cycle();
    chk("t1_nbursts", 32'(burst_addrs.size()), 4);
    chk("t1_ndone", 32'(n_done), 1);
    for (int i = 0; i < 4 && i < burst_addrs.size(); i++) begin
      chk("t1_addr", 32'(burst_addrs[i]), 32'(lit_addr[i]));
      chk("t1_bank", 32'(burst_banks[i]), 2);
    end
    chk("t3_npix", 32'(seen.size()), 16);
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("t3_pix", 32'(seen[i]), 32'(i + 1));

    // idle consumer: stalls after two bursts until four slots free
    consume_pct = 0; burst_addrs.delete(); burst_banks.delete();
    disp_bank = 1; fs_pending = 1;
    repeat (80) cycle();
    chk("t2_bursts", 32'(burst_addrs.size()), 2);
    chk("t2_model_full", 32'(m_q.size()), 8);
    chk("t2_req_low", 32'(bus.read_burst_req), 0);
    if (burst_banks.size() > 0) chk("t2_bank", 32'(burst_banks[0]), 1);
    force_pop = 3;
    repeat (20) cycle();
    chk("t2_still_2", 32'(burst_addrs.size()), 2);
    force_pop = 1;
    repeat (30) cycle();
    chk("t2_third", 32'(burst_addrs.size()), 3);

    // restart two words into a burst
    burst_addrs.delete(); burst_banks.delete(); seen.delete();
    abort_after = 2; abort_fired = 0; abort_bank = 0;
    disp_bank = 3; fs_pending = 1;
    wait_bursts(2, 200, "t5_timeout");
    first_w = word;
    if (burst_addrs.size() >= 2) begin
      chk("t5_addr0", 32'(burst_addrs[0]), 0);
      chk("t5_addr1", 32'(burst_addrs[1]), 0);
      chk("t5_bank1", 32'(burst_banks[1]), 0);
    end
    abort_after = -1;
    consume_pct = 50; n_done = 0;
    for (int i = 0; i < 300 && seen.size() < 1; i++) cycle();
    if (seen.size() > 0) chk("t5_first_pix", 32'(seen[0]), 32'(first_w));
    else chk("t5_no_pix", 0, 1);
    wait_done(600, "t5_done_timeout");

    // frame_start together with the final finish
    repeat (5) cycle();
    burst_addrs.delete(); n_done = 0; fs_on_final = 1; disp_bank = 2; fs_pending = 1;
    wait_bursts(5, 800, "t6_timeout");
    fs_on_final = 0;
    if (burst_addrs.size() >= 5) begin
      chk("t6_addr3", 32'(burst_addrs[3]), 12);
      chk("t6_addr4", 32'(burst_addrs[4]), 0);
    end
    chk("t6_no_done", 32'(n_done), 0);

    // reset in the middle of a burst
    nb = burst_addrs.size();
    wait_bursts(nb + 1, 400, "t6r_timeout");
    for (int i = 0; i < 20 && !(busy && left < BL); i++) cycle();
    rst_n = 0;
    #1;
    chk("t6r_req", 32'(bus.read_burst_req), 0);
    chk("t6r_addr", 32'(bus.read_addr), 0);
    repeat (2) cycle();
    rst_n = 1;
    cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) consume_pct = $urandom_range(0, 100);
      if ($urandom_range(0, 99) == 0) begin
        disp_bank = 2'($urandom_range(0, 3)); fs_pending = 1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
